// File: rtl/logphy_param_queue.sv
// Parametrised first-word-fall-through valid/ready FIFO for the logical PHY datapath.
// Provides occupancy, almost-full/almost-empty watermarks, a high-water mark and a synchronous flush.
module logphy_param_queue #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_TH  = 3,
    parameter int unsigned AEMPTY_TH = 1,
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid_i,
    output logic              enq_rdy_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              deq_valid_o,
    input  logic              deq_rdy_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CNT_W-1:0]  hwm_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] hwm_q, hwm_d;

    logic enq_fire;
    logic deq_fire;

    // Ready/valid depend only on the count register, so there is no path from deq_rdy_i to enq_rdy_o.
    assign enq_rdy_o   = (count_q != DEPTH_C);
    assign deq_valid_o = (count_q != '0);
    assign enq_fire    = enq_valid_i & enq_rdy_o;
    assign deq_fire    = deq_rdy_i & deq_valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hwm_d    = hwm_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq_fire && !deq_fire) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq_fire && !enq_fire) begin
                count_d = count_q - CNT_W'(1);
            end
        end
        if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    // Storage is deliberately not reset; data_o is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush_i) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    assign data_o         = deq_valid_o ? mem[rd_ptr_q] : '0;
    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);
    assign hwm_o          = hwm_q;

endmodule

// File: doc/logphy_param_queue.md
Name: logphy_param_queue

Overview:
Parametrised valid/ready FIFO for the UCIe logical PHY datapath. It is the successor to the fixed 128-bit Queue.
- Generic over data width and depth.
- First-word-fall-through output.
- Occupancy count, almost-full/almost-empty watermarks, high-water-mark diagnostic.
- Synchronous flush for link retrain and error recovery.
Sits between adapter-side flit producers and the lane-striping/transmit logic.

Parameters:
DATA_W, 128, payload width in bits (>=1)
DEPTH, 4, number of entries; power of 2, >=2
AFULL_TH, 3, almost_full_o asserted when count >= AFULL_TH; range 1..DEPTH
AEMPTY_TH, 1, almost_empty_o asserted when count <= AEMPTY_TH; range 0..DEPTH-1
(derived) CNT_W = $clog2(DEPTH)+1

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low; state cleared immediately while 0, released synchronously by the integrator
enq_valid_i  in  1  producer has data_i
enq_rdy_o  out  1  queue can accept
data_i  in  DATA_W  enqueue payload
deq_valid_o  out  1  data_o holds head entry
deq_rdy_i  in  1  consumer accepts head
data_o  out  DATA_W  head entry; forced to 0 when deq_valid_o=0
flush_i  in  1  synchronous clear of contents
count_o  out  CNT_W  current occupancy 0..DEPTH
almost_full_o  out  1  count_o >= AFULL_TH
almost_empty_o  out  1  count_o <= AEMPTY_TH
hwm_o  out  CNT_W  maximum count_o reached since reset

Behaviour:
- Storage: DEPTH x DATA_W array, not reset.
- Pointers: wr_ptr and rd_ptr, $clog2(DEPTH) bits each; wrap naturally from DEPTH-1 to 0. Count register is CNT_W bits.
- Reset (reset=0, async) sets:
  - count_o=0, enq_rdy_o=1, deq_valid_o=0, data_o=0.
  - almost_full_o=0, almost_empty_o=1, hwm_o=0; pointers=0.
- enq_rdy_o = (count != DEPTH).
  - No combinational path from deq_rdy_i. When full, enq is refused even if a deq occurs in the same cycle.
- deq_valid_o = (count != 0). No empty bypass: a word enqueued at edge N is first visible on data_o/deq_valid_o after edge N.
- Transfer rules:
  - enq fires when enq_valid_i & enq_rdy_o at a rising edge: mem[wr_ptr]<=data_i, wr_ptr++.
  - deq fires when deq_valid_o & deq_rdy_i: rd_ptr++.
- Count update:
  - enq only: +1.
  - deq only: -1.
  - both: unchanged; data order preserved.
  - neither: hold.
- data_o = mem[rd_ptr] while deq_valid_o=1. It must stay stable while deq_valid_o=1 and deq_rdy_i=0.
- Flush:
  - flush_i=1 at an edge: pointers and count go to 0. Overrides any enq/deq in the same cycle; the enq is dropped and not counted.
  - Outputs return to empty values after that edge. hwm_o is unaffected.
- Watermarks: almost_full_o and almost_empty_o are decoded from the count register, so they change only after clock edges or reset.
- hwm_o: updated to the next count value when that value exceeds hwm_o. Cleared only by reset.
- Reset mid-operation: all outputs take reset values immediately on reset falling, with no clock required. Contents are discarded.
- Input handling: enq_valid_i/data_i may change while enq_rdy_o=0; no sticky capture.
- X-checks: no X on any output after reset, for any DATA_W.

Test Plan:
1. Reset check (DATA_W=128, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1). Hold reset=0 for 2 cycles -> enq_rdy_o=1, deq_valid_o=0, data_o=0, count_o=0, almost_empty_o=1, almost_full_o=0, hwm_o=0.
2. Fill to full. Enqueue 128'hA0, A1, A2, A3 on 4 consecutive edges with deq_rdy_i=0 ->
   - count_o 1,2,3,4; almost_empty_o drops at count 2; almost_full_o rises at count 3; enq_rdy_o=0 at count 4.
   - A 5th word 128'hA4 held valid 3 cycles is not accepted; count_o stays 4; hwm_o=4.
3. Drain and wrap. Set deq_rdy_i=1 and drain -> data_o shows A0, A1, A2, A3 in order, then deq_valid_o=0, data_o=0. Then enqueue B0..B5 while dequeuing every other cycle -> pointers wrap; output order B0..B5 exact.
4. Simultaneous transfers.
   - count=2, enq_valid_i=1 and deq_rdy_i=1 for 3 cycles -> count_o stays 2; FIFO order kept.
   - count=4, enq_valid_i=1 and deq_rdy_i=1 -> deq only; count_o=3 next cycle.
5. Flush. At count=3, assert flush_i=1 with enq_valid_i=1 data_i=128'hCC for one edge -> count_o=0, deq_valid_o=0, data_o=0, hwm_o unchanged. 128'hCC never appears on data_o.
6. Async reset mid-operation. At count=3, drive reset=0 midway between edges -> all outputs take reset values within the same timestep, before the next clk edge. After release, first enqueue 128'hDD appears as head.
